// File: rtl/typing_pkg.sv
// -----------------------------------------------------------------------------
// typing_pkg
// Shared types and constants for the typing-tutor round sequencer.
//   state_t    : round FSM states
//   DIGIT_MAX  : largest displayable digit, used for score saturation and
//                target folding
//   LFSR_TAPS  : feedback taps of the 4-bit target LFSR (bits 3 and 2)
//   digit_of() : folds a 4-bit LFSR value (1..15) onto a decimal digit 0..9
// -----------------------------------------------------------------------------
package typing_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

  // Values 10..15 wrap onto 0..5 so every LFSR state names a keypad digit.
  function automatic logic [3:0] digit_of(input logic [3:0] value);
    logic [3:0] folded;
    folded = value;
    if (value > DIGIT_MAX) begin
      folded = value - 4'd10;
    end
    return folded;
  endfunction

endpackage : typing_pkg

// File: rtl/lfsr4.sv
// -----------------------------------------------------------------------------
// lfsr4
// 4-bit Fibonacci LFSR, next = {q[2:0], q[3]^q[2]}, maximal period 15.
// Advances only when step is high, so the owner decides when a new target
// is drawn.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset, loads SEED
//   step   in   advance one state this cycle
//   q      out  current LFSR state (never zero for a nonzero SEED)
// -----------------------------------------------------------------------------
module lfsr4
  import typing_pkg::*;
#(
  parameter logic [3:0] SEED = 4'b0001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  output logic [3:0] q
);

  logic feedback;

  assign feedback = ^(q & LFSR_TAPS);

  // NOTE: registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (step) begin
      q <= {q[2:0], feedback};
    end
  end

endmodule : lfsr4

// File: rtl/typing_round_ctrl.sv
// -----------------------------------------------------------------------------
// typing_round_ctrl
// Round sequencer for the typing tutor: owns the target digit, the score and
// the seconds remaining, grades keypresses and feeds the four-digit display.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   start      in   pulse, begins a round from IDLE or DONE
//   tick_1hz   in   pulse, once per second
//   key_valid  in   pulse, key_code valid this cycle
//   key_code   in   pressed digit (10..15 always grade as a miss)
//   target     out  digit to type, 0..9 (display random_num_in)
//   score      out  hits, 0..9 (display score_in)
//   time_left  out  seconds remaining (display time_in)
//   hit        out  one-cycle pulse on a correct key
//   miss       out  one-cycle pulse on a wrong key
//   game_over  out  high while the round is finished
// All outputs come straight from flops or from flops through the target fold;
// no input has a combinational path to an output.
// -----------------------------------------------------------------------------
module typing_round_ctrl
  import typing_pkg::*;
#(
  parameter int         GAME_SECONDS = 15,
  parameter logic [3:0] LFSR_SEED    = 4'b0001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       tick_1hz,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] target,
  output logic [3:0] score,
  output logic [3:0] time_left,
  output logic       hit,
  output logic       miss,
  output logic       game_over
);

  localparam logic [3:0] ROUND_TIME = 4'(GAME_SECONDS);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] lfsr_q;
  logic       key_match;
  logic       lfsr_step;
  logic       final_tick;

  // ---------------------------------------------------------------------------
  // Target generation: a new digit is drawn at round start and after each hit.
  // ---------------------------------------------------------------------------
  lfsr4 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  assign target     = digit_of(lfsr_q);
  assign key_match  = (key_code == target);
  assign lfsr_step  = (state == LOAD) || ((state == PLAY) && key_valid && key_match);
  assign final_tick = (state == PLAY) && tick_1hz && (time_left == 4'd1);
  assign game_over  = (state == DONE);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt is assigned a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: state_nxt = PLAY;
      PLAY: if (final_tick) state_nxt = DONE;
      DONE: if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, score, timer and grading pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      score     <= 4'd0;
      time_left <= ROUND_TIME;
      hit       <= 1'b0;
      miss      <= 1'b0;
    end else begin
      state <= state_nxt;
      hit   <= 1'b0;
      miss  <= 1'b0;

      case (state)
        LOAD: begin
          score     <= 4'd0;
          time_left <= ROUND_TIME;
        end

        PLAY: begin
          // A key and a tick in the same cycle both take effect, including
          // the final tick: the key is graded while the FSM moves to DONE.
          if (key_valid) begin
            if (key_match) begin
              hit <= 1'b1;
              if (score < DIGIT_MAX) begin
                score <= score + 4'd1;
              end
            end else begin
              miss <= 1'b1;
              if (score != 4'd0) begin
                score <= score - 4'd1;
              end
            end
          end
          if (tick_1hz) begin
            time_left <= time_left - 4'd1;
          end
        end

        // IDLE and DONE freeze the round values; keys and ticks are dropped,
        // and a start in DONE wins over a simultaneous key.
        default: ;
      endcase
    end
  end

endmodule : typing_round_ctrl

// File: tb/tb_typing_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_typing_round_ctrl
// Self-checking bench: directed round scenarios with literal expectations,
// then randomized traffic. A round-level reference model runs alongside and
// every output is compared against it on each falling clock edge.
// -----------------------------------------------------------------------------
module tb_typing_round_ctrl;

  localparam int         GS   = 15;
  localparam logic [3:0] SEED = 4'b0001;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       tick_1hz;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] target;
  logic [3:0] score;
  logic [3:0] time_left;
  logic       hit;
  logic       miss;
  logic       game_over;

  typing_round_ctrl #(
    .GAME_SECONDS (GS),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tick_1hz  (tick_1hz),
    .key_valid (key_valid),
    .key_code  (key_code),
    .target    (target),
    .score     (score),
    .time_left (time_left),
    .hit       (hit),
    .miss      (miss),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit run         = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. The target stream is the precomputed 15-entry LFSR
  // sequence walked by an index; round phase is tracked by name.
  // ---------------------------------------------------------------------------
  int    seq[15];
  int    m_idx;
  int    m_score;
  int    m_time;
  bit    m_hit;
  bit    m_miss;
  string m_phase;

  initial begin
    logic [3:0] v;
    v = SEED;
    for (int i = 0; i < 15; i++) begin
      seq[i] = int'(v);
      v = {v[2:0], v[3] ^ v[2]};
    end
  end

  function automatic int m_target();
    int raw;
    raw = seq[m_idx];
    return (raw >= 10) ? raw - 10 : raw;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = "idle"; m_idx = 0; m_score = 0; m_time = GS;
      m_hit = 0; m_miss = 0;
    end else begin
      int t;
      t = m_target();
      m_hit = 0; m_miss = 0;
      if (m_phase == "idle" || m_phase == "done") begin
        if (start) m_phase = "load";
      end else if (m_phase == "load") begin
        m_score = 0; m_time = GS; m_idx = (m_idx + 1) % 15; m_phase = "play";
      end else begin
        if (key_valid) begin
          if (int'(key_code) == t) begin
            m_hit = 1; m_score = (m_score < 9) ? m_score + 1 : 9; m_idx = (m_idx + 1) % 15;
          end else begin
            m_miss = 1; m_score = (m_score > 0) ? m_score - 1 : 0;
          end
        end
        if (tick_1hz) begin
          m_time = m_time - 1;
          if (m_time == 0) m_phase = "done";
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run && rst_n) begin
      check("model_target",    8'(target),    8'(m_target()));
      check("model_score",     8'(score),     8'(m_score));
      check("model_time_left", 8'(time_left), 8'(m_time));
      check("model_hit",       8'(hit),       8'(m_hit));
      check("model_miss",      8'(miss),      8'(m_miss));
      check("model_game_over", 8'(game_over), 8'(m_phase == "done"));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step(input bit s, input bit kv, input logic [3:0] kc, input bit tk);
    start = s; key_valid = kv; key_code = kc; tick_1hz = tk;
    @(posedge clk); #1;
    start = 0; key_valid = 0; tick_1hz = 0;
  endtask

  task automatic do_start();
    step(1, 0, 4'd0, 0);
    step(0, 0, 4'd0, 0);
  endtask

  task automatic press(input logic [3:0] k);
    step(0, 1, k, 0);
  endtask

  task automatic tick();
    step(0, 0, 4'd0, 1);
  endtask

  task automatic press_hit();
    press(4'(m_target()));
  endtask

  int exp_tgt[4] = '{4, 9, 3, 6};
  int key_seq[4] = '{2, 4, 9, 3};

  initial begin
    rst_n = 0; start = 0; tick_1hz = 0; key_valid = 0; key_code = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    run = 1;

    // Reset values
    check("rst_target", 8'(target), 8'd1);
    check("rst_score", 8'(score), 8'd0);
    check("rst_time", 8'(time_left), 8'd15);
    check("rst_game_over", 8'(game_over), 8'd0);
    // Ignored in IDLE
    step(0, 1, 4'd1, 1);
    check("idle_ignore_hit", 8'(hit), 8'd0);
    check("idle_ignore_time", 8'(time_left), 8'd15);

    // Round start
    do_start();
    check("start_target", 8'(target), 8'd2);
    check("start_score", 8'(score), 8'd0);
    check("start_time", 8'(time_left), 8'd15);

    // Misses at score floor
    press(4'd7);
    check("miss7_pulse", 8'(miss), 8'd1);
    check("miss7_score", 8'(score), 8'd0);
    check("miss7_target", 8'(target), 8'd2);
    press(4'd12);
    check("miss12_pulse", 8'(miss), 8'd1);
    check("miss12_hit", 8'(hit), 8'd0);
    step(0, 0, 4'd0, 0);
    check("miss_one_cycle", 8'(miss), 8'd0);

    // Hit sequence
    for (int i = 0; i < 4; i++) begin
      press(4'(key_seq[i]));
      check("hit_pulse", 8'(hit), 8'd1);
      check("hit_target", 8'(target), 8'(exp_tgt[i]));
      check("hit_score", 8'(score), 8'(i + 1));
    end

    // Saturation
    for (int i = 0; i < 10; i++) press_hit();
    check("sat_score", 8'(score), 8'd9);
    check("sat_hit", 8'(hit), 8'd1);

    // Count down to DONE
    for (int i = 0; i < 15; i++) begin
      tick();
      check("countdown", 8'(time_left), 8'(14 - i));
    end
    check("done_game_over", 8'(game_over), 8'd1);
    step(0, 1, 4'(m_target()), 1);
    step(0, 1, 4'd15, 1);
    check("done_frozen_score", 8'(score), 8'd9);
    check("done_frozen_time", 8'(time_left), 8'd0);
    check("done_no_miss", 8'(miss), 8'd0);

    // start and key together in DONE: start wins
    step(1, 1, 4'(m_target()), 0);
    check("restart_no_hit", 8'(hit), 8'd0);
    step(0, 0, 4'd0, 0);
    check("restart_score", 8'(score), 8'd0);
    check("restart_time", 8'(time_left), 8'd15);
    check("restart_game_over", 8'(game_over), 8'd0);

    // Correct key on the final tick
    for (int i = 0; i < 14; i++) tick();
    step(0, 1, 4'(m_target()), 1);
    check("final_key_score", 8'(score), 8'd1);
    check("final_key_hit", 8'(hit), 8'd1);
    check("final_key_game_over", 8'(game_over), 8'd1);
    check("final_key_time", 8'(time_left), 8'd0);

    // Asynchronous reset mid-round
    do_start();
    for (int i = 0; i < 5; i++) press_hit();
    for (int i = 0; i < 8; i++) tick();
    check("pre_rst_score", 8'(score), 8'd5);
    check("pre_rst_time", 8'(time_left), 8'd7);
    #2 rst_n = 0;
    #1;
    check("mid_rst_target", 8'(target), 8'd1);
    check("mid_rst_score", 8'(score), 8'd0);
    check("mid_rst_time", 8'(time_left), 8'd15);
    check("mid_rst_game_over", 8'(game_over), 8'd0);
    @(posedge clk); #1 rst_n = 1;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      bit s, kv, tk;
      logic [3:0] kc;
      s  = ($urandom_range(0, 39) == 0);
      tk = ($urandom_range(0, 5) == 0);
      kv = ($urandom_range(0, 2) == 0);
      kc = ($urandom_range(0, 1) == 0) ? 4'(m_target()) : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
      end else begin
        step(s, kv, kc, tk);
      end
    end

    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_typing_round_ctrl
